uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- UART transmitter that sits directly downstream of the peripheral's 4-deep byte FIFO and drains it.
- Pops one byte whenever the FIFO is non-empty and the transmitter is idle, then serialises it LSB-first on a single TX line.
- Frame is 8N1 by default, with 1 or 2 stop bits, plus optional parity.
- The APB register slave writes bytes into the FIFO. This block is the FIFO's only reader.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. DIV = CLK_FREQ/BAUD, integer division, must be ≥ 2. Every bit lasts exactly DIV clocks.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  transmit enable. While low, no new pop is issued; a frame already in progress completes.
- fifo_rdata  in  8  FIFO head data. It is combinational (show-ahead) and valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop strobe, one clock wide.
- tx  out  1  serial line, idle high, registered.
- tx_busy  out  1  high from the cycle after a pop through the last stop-bit clock.
- tx_done  out  1  one-clock pulse in the last clock of the final stop bit.

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_done=0, fifo_rd_en=0. Reset puts the FSM in IDLE and clears the baud counter, bit counter and shift register.
- Reset mid-frame: the frame is abandoned, tx=1 on the first post-reset cycle, and no pop is issued while reset is high.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - fifo_rd_en = (state==IDLE) & en & ~fifo_empty. This is combinational from registered state and the inputs.
  - On that edge, fifo_rdata is captured into the shift register and the FSM moves to START.
  - tx=0 and tx_busy=1 from the next cycle.
- Baud counter:
  - Counts 0..DIV-1 in every non-IDLE state and is cleared on each state or bit change.
  - Every bit period is exactly DIV clocks.
- START: 1 bit of tx=0, then go to DATA.
- DATA:
  - 8 bits, shift register bit0 first; the register shifts right at the end of each bit.
  - A 3-bit counter wraps at 7, after which the FSM goes to PARITY or STOP.
- STOP:
  - tx=1 for STOP_BITS×DIV clocks.
  - tx_done=1 in the final clock, after which the FSM goes to IDLE.
- Frame timing:
  - Back-to-back frames: the pop happens in the first IDLE cycle after STOP.
  - The start-to-start period is (10+STOP_BITS-1+P)×DIV + 1 clocks, where P=1 if parity is present.
- Simultaneous events:
  - fifo_empty falling while the FSM is in a non-IDLE state is ignored until IDLE.
  - en falling during a frame: the frame finishes and no further pop is issued.
- Boundary cases:
  - fifo_empty=1 in IDLE: no pop; tx stays at 1.
  - A full FIFO is never the concern of this block.
  - The FIFO must never be popped when empty; fifo_rd_en is never high while fifo_empty=1.
- Width rules:
  - Baud counter width is $clog2(DIV).
  - The DIV computation is done at elaboration time. No runtime division is performed.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, one bit period long.
  - tx = ^data_byte XOR PARITY_ODD. data_byte is the byte captured at pop, kept in a separate 8-bit register.
  - The frame is 11 bits with STOP_BITS=1.
- When undefined:
  - The PARITY state, the parity register and PARITY_ODD usage are removed.
  - DATA goes straight to STOP and the frame is 10 bits.

Test Plan:
- Reset behaviour:
  - Stimulus: reset held 3 clocks with fifo_empty=0, en=1.
  - Response: fifo_rd_en=0 and tx=1 throughout. Pop occurs in the first cycle after reset falls.
- Single byte, CLK_FREQ=100, BAUD=10 (DIV=10):
  - Stimulus: fifo_rdata=0xA5.
  - Response: one pop; tx sequence 0, then 1,0,1,0,0,1,0,1, then 1, each held exactly 10 clocks; tx_done pulses at clock 100 after the pop.
- Back-to-back bytes:
  - Stimulus: FIFO holds 0x00 then 0xFF.
  - Response: exactly two pops, 101 clocks apart; the second start bit begins 1 clock after the first stop bit ends.
- Enable gating:
  - Stimulus: deassert en mid-DATA with 2 bytes queued.
  - Response: the current frame completes, no second pop occurs, and tx stays 1. Re-asserting en pops in the next cycle.
- Reset mid-frame:
  - Stimulus: assert reset in DATA bit 4.
  - Response: tx=1 and tx_busy=0 the next cycle, no tx_done, and the FSM restarts cleanly on the next byte.
- With UART_TX_PARITY_EN, PARITY_ODD=0:
  - Stimulus: byte 0x07.
  - Response: parity bit = 1 and the frame is 110 clocks.
  - With PARITY_ODD=1 the parity bit is 0.

Source files
------------

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-side handshake between the 4-deep byte FIFO and its draining UART transmitter.
// master = the reader that issues pops; slave = the FIFO that presents show-ahead data.
interface uart_tx_fifo_drain_if;
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_rd_en;

    modport master (input fifo_rdata, input fifo_empty, output fifo_rd_en);
    modport slave  (output fifo_rdata, output fifo_empty, input fifo_rd_en);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a show-ahead byte FIFO, sending 8 data bits LSB-first plus 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (even or odd, selected by PARITY_ODD) between data and stop.
module uart_tx_fifo_drain #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    uart_tx_fifo_drain_if.master       fifo,
    output logic                       tx,
    output logic                       tx_busy,
    output logic                       tx_done
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    // Bad parameter sets are rejected at elaboration rather than producing a wrong line rate.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo_drain: CLK_FREQ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_fifo_drain: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx_fifo_drain: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PARITY_SENSE = 1'(PARITY_ODD);
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shift_reg, shift_n;
    logic             tx_n;
    logic             pop;
    logic             done;
    logic             baud_last;
`ifdef UART_TX_PARITY_EN
    logic [7:0]       data_byte, data_n;
`endif

    assign baud_last = (baud_cnt == BAUD_LAST);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        pop     = 1'b0;
        done    = 1'b0;
`ifdef UART_TX_PARITY_EN
        data_n  = data_byte;
`endif
        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                // Reset gates the pop so the FIFO is never read while the block is held.
                if (!reset && en && !fifo.fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo.fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    data_n  = fifo.fifo_rdata;
`endif
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == STOP_LAST) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                bit_n   = '0;
                state_n = IDLE;
            end
        endcase

        // The line level is derived from the state being entered so tx itself can be a flop.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = ^data_byte ^ PARITY_SENSE;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            data_byte <= '0;
`endif
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
`ifdef UART_TX_PARITY_EN
            data_byte <= data_n;
`endif
        end
    end

    assign fifo.fifo_rd_en = pop;
    assign tx_busy         = (state != IDLE);
    assign tx_done         = done;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain at DIV=10: reset, single and back-to-back frames, enable gating, mid-frame reset.
// A small 4-deep show-ahead FIFO model feeds the DUT; parity frames are checked when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo_drain;
    localparam int CLK_FREQ   = 100;
    localparam int BAUD       = 10;
    localparam int DIV        = CLK_FREQ / BAUD;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (10 + STOP_BITS - 1 + P) * DIV;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic tx;
    logic tx_busy;
    logic tx_done;

    uart_tx_fifo_drain_if fif ();

    uart_tx_fifo_drain #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .fifo   (fif),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: the bench pushes at negedges, the DUT pops at posedges.
    logic [7:0] mem [4];
    logic [2:0] wr_ptr = '0;
    logic [2:0] rd_ptr = '0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         illegal_pops = 0;
    int         pop_cyc [16];

    assign fif.fifo_empty = (wr_ptr == rd_ptr);
    assign fif.fifo_rdata = mem[rd_ptr[1:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fif.fifo_rd_en) begin
            if (fif.fifo_empty) illegal_pops <= illegal_pops + 1;
            if (pop_cnt < 16) pop_cyc[pop_cnt] <= cyc;
            pop_cnt <= pop_cnt + 1;
            rd_ptr  <= rd_ptr + 3'd1;
        end
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[1:0]] = b;
        wr_ptr = wr_ptr + 3'd1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " tx"}, 32'(tx), 32'd1);
        check({tag, " busy"}, 32'(tx_busy), 32'd0);
        check({tag, " done"}, 32'(tx_done), 32'd0);
        check({tag, " rd_en"}, 32'(fif.fifo_rd_en), 32'd0);
    endtask

    // Called where a pop is expected in the current cycle; follows the whole frame clock by clock.
    task automatic check_frame(input logic [7:0] b, input string tag, input int drop_at);
        logic exp_tx;
        int   idx;
        check({tag, " pop"}, 32'(fif.fifo_rd_en), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            idx = (c - 1) / DIV;
            if (idx == 0)                exp_tx = 1'b0;
            else if (idx <= 8)           exp_tx = b[idx-1];
            else if (P == 1 && idx == 9) exp_tx = ^b ^ 1'(PARITY_ODD);
            else                         exp_tx = 1'b1;
            check($sformatf("%s c%0d tx", tag, c), 32'(tx), 32'(exp_tx));
            check($sformatf("%s c%0d busy", tag, c), 32'(tx_busy), 32'd1);
            check($sformatf("%s c%0d done", tag, c), 32'(tx_done), 32'(c == FRAME));
            check($sformatf("%s c%0d rd_en", tag, c), 32'(fif.fifo_rd_en), 32'd0);
            if (c == drop_at) en = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        push(8'hA5);

        // Reset held 3 clocks with data waiting: no pop, line idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("reset%0d", i));
        end
        reset = 1'b0;
        #1;
        check_frame(8'hA5, "a5", 0);
        check("a5 pops", 32'(pop_cnt), 32'd1);

        // Empty FIFO in IDLE, then two bytes back-to-back.
        @(negedge clk);
        check_idle("empty");
        push(8'h00);
        push(8'hFF);
        #1;
        check_frame(8'h00, "b2b0", 0);
        @(negedge clk);
        check("b2b gap tx", 32'(tx), 32'd1);
        check("b2b gap busy", 32'(tx_busy), 32'd0);
        check_frame(8'hFF, "b2b1", 0);
        check("b2b pops", 32'(pop_cnt), 32'd3);
        check("b2b spacing", 32'(pop_cyc[2] - pop_cyc[1]), 32'(FRAME + 1));

        // Enable dropped during DATA bit 2 with two bytes queued.
        @(negedge clk);
        push(8'h3C);
        push(8'hC3);
        #1;
        check_frame(8'h3C, "en0", 35);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_idle($sformatf("gated%0d", i));
        end
        check("gated pops", 32'(pop_cnt), 32'd4);
        en = 1'b1;
        #1;
        check_frame(8'hC3, "en1", 0);
        check("en pops", 32'(pop_cnt), 32'd5);

        // Reset asserted in DATA bit 4 of 0x5A.
        @(negedge clk);
        push(8'h5A);
        #1;
        check("rst pop", 32'(fif.fifo_rd_en), 32'd1);
        @(posedge clk);
        repeat (55) @(negedge clk);
        check("rst bit4 tx", 32'(tx), 32'd1);
        check("rst bit4 busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("rst hit");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle($sformatf("post rst%0d", i));
        end
        push(8'h81);
        #1;
        check_frame(8'h81, "restart", 0);
        check("restart pops", 32'(pop_cnt), 32'd7);

`ifdef UART_TX_PARITY_EN
        @(negedge clk);
        push(8'h07);
        #1;
        check_frame(8'h07, "par07", 0);
        check("par pops", 32'(pop_cnt), 32'd8);
`endif

        @(negedge clk);
        check_idle("final");
        check("illegal pops", 32'(illegal_pops), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
